dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between the CPU control path and the board I/O port
//  (switch-entry writes, display read-back). Fixed priority to the CPU with an anti-starvation

---
 rtl/dmem_arbiter.sv | 91 +++++++++
 tb/tb_dmem_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU control path and the board I/O port.
// CPU has fixed priority; a starvation counter forces an I/O grant after STARVE_MAX lost cycles.
module dmem_arbiter #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_gnt,
    output logic              io_rvalid,
    output logic [DATA_W-1:0] io_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        RD_NONE,
        RD_CPU,
        RD_IO
    } rd_owner_t;

    localparam logic [2:0] WAIT_MAX = 3'(STARVE_MAX);

    logic [2:0] io_wait;
    rd_owner_t  rd_owner;
    logic       io_force;

    always_comb begin
        io_force  = io_req && (io_wait == WAIT_MAX);
        // Requests seen during the reset cycle are ignored entirely.
        cpu_gnt   = !reset && cpu_req && !io_force;
        io_gnt    = !reset && io_req && (!cpu_req || io_force);
        cpu_stall = !reset && cpu_req && !cpu_gnt;

        mem_en    = cpu_gnt || io_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (io_gnt) begin
            mem_we    = io_we;
            mem_addr  = io_addr;
            mem_wdata = io_wdata;
        end

        // Gating with reset drops data of a read granted just before reset.
        cpu_rvalid = !reset && (rd_owner == RD_CPU);
        io_rvalid  = !reset && (rd_owner == RD_IO);
        cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
        io_rdata   = io_rvalid ? mem_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            io_wait  <= '0;
            rd_owner <= RD_NONE;
        end else begin
            if (!io_req || io_gnt)
                io_wait <= '0;
            else if (io_wait != WAIT_MAX)
                io_wait <= io_wait + 3'd1;

            if (cpu_gnt && !cpu_we)
                rd_owner <= RD_CPU;
            else if (io_gnt && !io_we)
                rd_owner <= RD_IO;
            else
                rd_owner <= RD_NONE;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small synchronous write-first memory.
// Preloaded memory contents: mem[i] = 15 - i.
module tb_dmem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we;
    logic [3:0] cpu_addr, cpu_wdata;
    logic       cpu_gnt, cpu_stall, cpu_rvalid;
    logic [3:0] cpu_rdata;
    logic       io_req, io_we;
    logic [3:0] io_addr, io_wdata;
    logic       io_gnt, io_rvalid;
    logic [3:0] io_rdata;
    logic       mem_en, mem_we;
    logic [3:0] mem_addr, mem_wdata;
    logic [3:0] mem_rdata;
    logic [3:0] mem [16];

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.ADDR_W(4), .DATA_W(4), .STARVE_MAX(3)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_gnt(io_gnt), .io_rvalid(io_rvalid), .io_rdata(io_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        io_req  = 0; io_we  = 0; io_addr  = 0; io_wdata  = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 4'd3;
        #1;
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got %0b want 0", mem_en); end
        checks++; if (cpu_gnt !== 1'b0) begin errors++; $display("FAIL reset_cpu_gnt got %0b want 0", cpu_gnt); end
        checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 4'd0) begin errors++; $display("FAIL reset_rvalid got %0b/%0h want 0/0", cpu_rvalid, cpu_rdata); end
        @(negedge clk);
        reset = 0;
        #1;
        checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL release_cpu_gnt got %0b want 1", cpu_gnt); end
        checks++; if (mem_addr !== 4'd3 || mem_en !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL release_mem got addr %0h en %0b we %0b want 3 1 0", mem_addr, mem_en, mem_we); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 4'hC) begin errors++; $display("FAIL release_rdata got %0b/%0h want 1/c", cpu_rvalid, cpu_rdata); end
        checks++; if (mem_en !== 1'b0 || mem_addr !== 4'd0 || mem_wdata !== 4'd0) begin errors++; $display("FAIL idle_mem got en %0b addr %0h wd %0h want 0 0 0", mem_en, mem_addr, mem_wdata); end
    endtask

    task automatic test_io_write_read();
        @(negedge clk);
        io_req = 1; io_we = 1; io_addr = 4'd5; io_wdata = 4'hA;
        #1;
        checks++; if (io_gnt !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 4'hA || cpu_gnt !== 1'b0) begin errors++; $display("FAIL io_write got gnt %0b we %0b wd %0h cgnt %0b want 1 1 a 0", io_gnt, mem_we, mem_wdata, cpu_gnt); end
        @(negedge clk);
        io_we = 0;
        #1;
        checks++; if (io_gnt !== 1'b1 || mem_we !== 1'b0 || io_rvalid !== 1'b0) begin errors++; $display("FAIL io_read_issue got gnt %0b we %0b rv %0b want 1 0 0", io_gnt, mem_we, io_rvalid); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (io_rvalid !== 1'b1 || io_rdata !== 4'hA) begin errors++; $display("FAIL io_read_data got %0b/%0h want 1/a", io_rvalid, io_rdata); end
        checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 4'd0) begin errors++; $display("FAIL io_read_cpu_quiet got %0b/%0h want 0/0", cpu_rvalid, cpu_rdata); end
    endtask

    // CPU reads addr 1 (=e), I/O reads addr 4 (=b); expected grant pattern C,C,C,I repeating.
    task automatic test_starvation();
        logic exp_io, prev_io;
        prev_io = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cpu_req = 1; cpu_we = 0; cpu_addr = 4'd1;
            io_req  = 1; io_we  = 0; io_addr  = 4'd4;
            exp_io = (i == 3) || (i == 7);
            #1;
            checks++; if (io_gnt !== exp_io || cpu_gnt !== !exp_io) begin errors++; $display("FAIL starve_gnt[%0d] got cpu %0b io %0b want cpu %0b io %0b", i, cpu_gnt, io_gnt, !exp_io, exp_io); end
            checks++; if (cpu_stall !== exp_io) begin errors++; $display("FAIL starve_stall[%0d] got %0b want %0b", i, cpu_stall, exp_io); end
            checks++; if (mem_addr !== (exp_io ? 4'd4 : 4'd1)) begin errors++; $display("FAIL starve_addr[%0d] got %0h want %0h", i, mem_addr, exp_io ? 4'd4 : 4'd1); end
            if (i > 0) begin
                checks++; if (cpu_rvalid !== !prev_io || io_rvalid !== prev_io || (prev_io ? io_rdata : cpu_rdata) !== (prev_io ? 4'hB : 4'hE)) begin errors++; $display("FAIL starve_rdata[%0d] got crv %0b cd %0h irv %0b id %0h prev_io %0b", i, cpu_rvalid, cpu_rdata, io_rvalid, io_rdata, prev_io); end
            end
            prev_io = exp_io;
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_pipeline();
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 4'd2;
        #1;
        checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL pipe_cpu_gnt got %0b want 1", cpu_gnt); end
        @(negedge clk);
        cpu_req = 0; io_req = 1; io_we = 0; io_addr = 4'd7;
        #1;
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 4'hD || io_gnt !== 1'b1 || io_rvalid !== 1'b0) begin errors++; $display("FAIL pipe_t1 got crv %0b cd %0h ignt %0b irv %0b want 1 d 1 0", cpu_rvalid, cpu_rdata, io_gnt, io_rvalid); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (io_rvalid !== 1'b1 || io_rdata !== 4'h8 || cpu_rvalid !== 1'b0) begin errors++; $display("FAIL pipe_t2 got irv %0b id %0h crv %0b want 1 8 0", io_rvalid, io_rdata, cpu_rvalid); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        cpu_req = 1; cpu_we = 1; cpu_addr = 4'd9; cpu_wdata = 4'h6;
        #1;
        checks++; if (cpu_gnt !== 1'b1 || mem_we !== 1'b1 || cpu_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_write got gnt %0b we %0b rv %0b want 1 1 0", cpu_gnt, mem_we, cpu_rvalid); end
        @(negedge clk);
        cpu_we = 0;
        #1;
        checks++; if (cpu_gnt !== 1'b1 || cpu_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_read_issue got gnt %0b rv %0b want 1 0", cpu_gnt, cpu_rvalid); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 4'h6) begin errors++; $display("FAIL b2b_read_data got %0b/%0h want 1/6", cpu_rvalid, cpu_rdata); end
    endtask

    task automatic test_reset_kills_rvalid();
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 4'd2;
        #1;
        checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL rstkill_gnt got %0b want 1", cpu_gnt); end
        @(negedge clk);
        idle(); reset = 1;
        #1;
        checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 4'd0) begin errors++; $display("FAIL rstkill_rvalid got %0b/%0h want 0/0", cpu_rvalid, cpu_rdata); end
        @(negedge clk);
        reset = 0;
        #1;
        checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rstkill_after got %0b want 0", cpu_rvalid); end
    endtask

    // Two lost I/O cycles, then withdrawal: the wait count must restart from zero.
    task automatic test_withdraw();
        logic exp_io;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            cpu_req = 1; cpu_we = 1; cpu_addr = 4'd0; cpu_wdata = 4'h1;
            io_req  = 1; io_we  = 1; io_addr  = 4'd6; io_wdata  = 4'h3;
            #1;
            checks++; if (cpu_gnt !== 1'b1 || io_gnt !== 1'b0 || cpu_stall !== 1'b0) begin errors++; $display("FAIL wd_contend[%0d] got cgnt %0b ignt %0b st %0b want 1 0 0", i, cpu_gnt, io_gnt, cpu_stall); end
        end
        @(negedge clk);
        io_req = 0;
        #1;
        checks++; if (cpu_gnt !== 1'b1 || cpu_stall !== 1'b0 || io_gnt !== 1'b0 || mem_addr !== 4'd0) begin errors++; $display("FAIL wd_drop got cgnt %0b st %0b ignt %0b addr %0h want 1 0 0 0", cpu_gnt, cpu_stall, io_gnt, mem_addr); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            io_req = 1;
            exp_io = (i == 3);
            #1;
            checks++; if (io_gnt !== exp_io || cpu_stall !== exp_io) begin errors++; $display("FAIL wd_restart[%0d] got ignt %0b st %0b want %0b %0b", i, io_gnt, cpu_stall, exp_io, exp_io); end
        end
        @(negedge clk);
        idle();
        #1;
        checks++; if (io_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) begin errors++; $display("FAIL wd_no_rvalid got irv %0b crv %0b want 0 0", io_rvalid, cpu_rvalid); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 4'(15 - i);
        mem_rdata = '0;
        reset = 1;
        idle();
        test_reset();
        test_io_write_read();
        test_starvation();
        test_pipeline();
        test_back_to_back();
        test_reset_kills_rvalid();
        test_withdraw();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
